// File: rtl/seg7_pkg.sv
// Shared constants for the segment-pattern receive path: glyph encodings
// (active-high, [6:0] = g,f,e,d,c,b,a) and the stream FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG7_GLYPH_F = 7'h71;

    // Alternate renderings some display drivers use for 7 and 9.
    localparam logic [6:0] SEG7_ALT_7 = 7'h27;
    localparam logic [6:0] SEG7_ALT_9 = 7'h67;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FLUSH   = 1'b1
    } seg7_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational segment pattern -> hex digit decoder with illegal-glyph flag.
// Defining SEG7_DEC_LOOSE_EN also accepts the alternate 7 and 9 glyphs.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_digit = 4'h0;
        o_err   = 1'b0;
        case (i_seg)
            SEG7_GLYPH_0: o_digit = 4'h0;
            SEG7_GLYPH_1: o_digit = 4'h1;
            SEG7_GLYPH_2: o_digit = 4'h2;
            SEG7_GLYPH_3: o_digit = 4'h3;
            SEG7_GLYPH_4: o_digit = 4'h4;
            SEG7_GLYPH_5: o_digit = 4'h5;
            SEG7_GLYPH_6: o_digit = 4'h6;
            SEG7_GLYPH_7: o_digit = 4'h7;
            SEG7_GLYPH_8: o_digit = 4'h8;
            SEG7_GLYPH_9: o_digit = 4'h9;
            SEG7_GLYPH_A: o_digit = 4'hA;
            SEG7_GLYPH_B: o_digit = 4'hB;
            SEG7_GLYPH_C: o_digit = 4'hC;
            SEG7_GLYPH_D: o_digit = 4'hD;
            SEG7_GLYPH_E: o_digit = 4'hE;
            SEG7_GLYPH_F: o_digit = 4'hF;
`ifdef SEG7_DEC_LOOSE_EN
            SEG7_ALT_7:   o_digit = 4'h7;
            SEG7_ALT_9:   o_digit = 4'h9;
`else
            SEG7_ALT_7,
            SEG7_ALT_9:   o_err   = 1'b1;
`endif
            default:      o_err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_decode_stream.sv
// Segment-byte stream decoder: valid/ready in, 1-deep registered digit out,
// packed word assembly and saturating illegal-glyph counter. Option macro: SEG7_DEC_LOOSE_EN.
module seg7_decode_stream
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 0,
    parameter int NUM_DIGITS = 2,
    parameter int ERRW       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              seg_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              digit,
    output logic                    dp,
    output logic                    err,
    output logic [4*NUM_DIGITS-1:0] word,
    output logic                    word_valid,
    output logic [ERRW-1:0]         err_count
);

    localparam int              IDXW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    seg7_state_e             r_state;
    logic [IDXW-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_acc;
    logic [4*NUM_DIGITS-1:0] r_word;
    logic                    r_word_valid;
    logic                    r_out_valid;
    logic [3:0]              r_digit;
    logic                    r_dp;
    logic                    r_err;
    logic [ERRW-1:0]         r_err_count;

    logic [7:0]              w_seg;
    logic [3:0]              w_dec_digit;
    logic                    w_dec_err;
    logic                    w_accept;
    logic [4*NUM_DIGITS-1:0] w_acc_next;

    assign w_seg = (ACTIVE_LOW != 0) ? ~seg_in : seg_in;

    seg7_glyph_decode u_glyph_decode (
        .i_seg   (w_seg[6:0]),
        .o_digit (w_dec_digit),
        .o_err   (w_dec_err)
    );

    // frame_start blocks acceptance in the same cycle so the restart is clean.
    assign in_ready = (r_state == ST_COLLECT) & ~frame_start & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_idx, 2'b00} +: 4] = w_dec_digit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_COLLECT;
            r_idx        <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_digit      <= 4'h0;
            r_dp         <= 1'b0;
            r_err        <= 1'b0;
            r_err_count  <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            r_word_valid <= 1'b0;

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_digit     <= w_dec_digit;
                r_dp        <= w_seg[7];
                r_err       <= w_dec_err;
                if (w_dec_err && (r_err_count != ERR_MAX)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (r_idx == LAST_IDX) begin
                    r_idx        <= '0;
                    r_acc        <= '0;
                    r_word       <= w_acc_next;
                    r_word_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_acc <= w_acc_next;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Accept never coincides with frame_start or FLUSH, so these writes do not collide.
            case (r_state)
                ST_COLLECT: begin
                    if (frame_start) begin
                        r_state <= ST_FLUSH;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_COLLECT;
                    r_idx   <= '0;
                    r_acc   <= '0;
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign digit      = r_digit;
    assign dp         = r_dp;
    assign err        = r_err;
    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_seg7_decode_stream.sv
// Self-checking bench for seg7_decode_stream: directed table, handshake and
// frame corner cases, randomized bytes against a glyph-search reference model.
module tb_seg7_decode_stream;

    localparam int ND0 = 2;
    localparam int ND1 = 3;

`ifdef SEG7_DEC_LOOSE_EN
    localparam bit LOOSE = 1'b1;
`else
    localparam bit LOOSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance: active-high, 2 digits, 8-bit error counter
    logic           fs0, iv0, ir0, ov0, or0, dp0, er0, wv0;
    logic [7:0]     seg0;
    logic [3:0]     dg0;
    logic [4*ND0-1:0] wd0;
    logic [7:0]     ec0;

    // second instance: active-low, 3 digits, 2-bit error counter
    logic           fs1, iv1, ir1, ov1, or1, dp1, er1, wv1;
    logic [7:0]     seg1;
    logic [3:0]     dg1;
    logic [4*ND1-1:0] wd1;
    logic [1:0]     ec1;

    seg7_decode_stream #(.ACTIVE_LOW(0), .NUM_DIGITS(ND0), .ERRW(8)) dut0 (
        .clk(clk), .reset(reset), .frame_start(fs0), .in_valid(iv0), .in_ready(ir0),
        .seg_in(seg0), .out_valid(ov0), .out_ready(or0), .digit(dg0), .dp(dp0),
        .err(er0), .word(wd0), .word_valid(wv0), .err_count(ec0)
    );

    seg7_decode_stream #(.ACTIVE_LOW(1), .NUM_DIGITS(ND1), .ERRW(2)) dut1 (
        .clk(clk), .reset(reset), .frame_start(fs1), .in_valid(iv1), .in_ready(ir1),
        .seg_in(seg1), .out_valid(ov1), .out_ready(or1), .digit(dg1), .dp(dp1),
        .err(er1), .word(wd1), .word_valid(wv1), .err_count(ec1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: glyph lookup by search, digit queue for word packing.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void ref_decode(input logic [7:0] s, output logic [3:0] d, output logic e);
        d = 4'h0;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == s[6:0]) begin
                d = 4'(i);
                e = 1'b0;
            end
        end
        if (LOOSE && s[6:0] == 7'h27) begin d = 4'h7; e = 1'b0; end
        if (LOOSE && s[6:0] == 7'h67) begin d = 4'h9; e = 1'b0; end
    endfunction

    logic [3:0]       m_digits [$];
    int               m_errs = 0;
    logic [4*ND0-1:0] m_word = '0;

    task automatic model_accept0(input logic [3:0] d, input logic e, output logic exp_wv);
        m_digits.push_back(d);
        if (e && m_errs < 255) m_errs++;
        exp_wv = 1'b0;
        if (m_digits.size() == ND0) begin
            for (int i = 0; i < ND0; i++) m_word[4*i +: 4] = m_digits[i];
            m_digits.delete();
            exp_wv = 1'b1;
        end
    endtask

    task automatic xfer0(input logic [7:0] s, input logic [3:0] ed, input logic edp,
                         input logic ee, input string name);
        logic exp_wv;
        @(negedge clk);
        iv0 = 1'b1; seg0 = s; or0 = 1'b1; fs0 = 1'b0;
        #1 check({name, " in_ready"}, ir0, 1);
        @(posedge clk);
        #1;
        model_accept0(ed, ee, exp_wv);
        check({name, " out_valid"}, ov0, 1);
        check({name, " digit"}, dg0, ed);
        check({name, " dp"}, dp0, edp);
        check({name, " err"}, er0, ee);
        check({name, " word_valid"}, wv0, exp_wv);
        check({name, " word"}, wd0, m_word);
        check({name, " err_count"}, ec0, m_errs);
    endtask

    task automatic xfer1(input logic [7:0] s, input logic [3:0] ed, input logic edp,
                         input logic ee, input int eec, input string name);
        @(negedge clk);
        iv1 = 1'b1; seg1 = s; or1 = 1'b1; fs1 = 1'b0;
        #1 check({name, " in_ready"}, ir1, 1);
        @(posedge clk);
        #1;
        check({name, " out_valid"}, ov1, 1);
        check({name, " digit"}, dg1, ed);
        check({name, " dp"}, dp1, edp);
        check({name, " err"}, er1, ee);
        check({name, " err_count"}, ec1, eec);
    endtask

    typedef struct {
        logic [7:0] seg;
        logic [3:0] d;
        logic       dp;
        logic       err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [7:0] s;
        logic [3:0] d;
        logic       e;
        logic       wv;
        int         n1;

        vecs[0]  = '{8'h3F, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{8'h06, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 4'h8, 1'b1, 1'b0};
        vecs[3]  = '{8'h00, 4'h0, 1'b0, 1'b1};
        vecs[4]  = '{8'h5B, 4'h2, 1'b0, 1'b0};
        vecs[5]  = '{8'hCF, 4'h3, 1'b1, 1'b0};
        vecs[6]  = '{8'h77, 4'hA, 1'b0, 1'b0};
        vecs[7]  = '{8'h7C, 4'hB, 1'b0, 1'b0};
        vecs[8]  = '{8'h39, 4'hC, 1'b0, 1'b0};
        vecs[9]  = '{8'hDE, 4'hD, 1'b1, 1'b0};
        vecs[10] = '{8'h79, 4'hE, 1'b0, 1'b0};
        vecs[11] = '{8'h71, 4'hF, 1'b0, 1'b0};
        vecs[12] = '{8'h27, LOOSE ? 4'h7 : 4'h0, 1'b0, !LOOSE};
        vecs[13] = '{8'h67, LOOSE ? 4'h9 : 4'h0, 1'b0, !LOOSE};

        reset = 1'b1;
        fs0 = 1'b0; iv0 = 1'b0; or0 = 1'b1; seg0 = 8'h00;
        fs1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; seg1 = 8'h00;

        // reset state
        #79;
        check("rst out_valid", ov0, 0);
        check("rst digit", dg0, 0);
        check("rst dp", dp0, 0);
        check("rst err", er0, 0);
        check("rst word", wd0, 0);
        check("rst word_valid", wv0, 0);
        check("rst err_count", ec0, 0);
        #1 reset = 1'b0;
        #1 check("post-rst in_ready", ir0, 1);

        // directed table, streamed on consecutive cycles
        for (int i = 0; i < 14; i++) begin
            xfer0(vecs[i].seg, vecs[i].d, vecs[i].dp, vecs[i].err, $sformatf("vec%0d", i));
            if (i == 1) check("t1 word 0x10", wd0, 8'h10);
            if (i == 3) check("t2 err_count 1", ec0, 1);
        end

        // backpressure: one byte accepted, then held while consumer stalls
        @(negedge clk); iv0 = 1'b0; or0 = 1'b1;
        @(posedge clk); #1 check("bp drained", ov0, 0);
        @(negedge clk); iv0 = 1'b1; seg0 = 8'h5B; or0 = 1'b0;
        @(posedge clk); #1;
        model_accept0(4'h2, 1'b0, wv);
        check("bp first out_valid", ov0, 1);
        check("bp first digit", dg0, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); seg0 = 8'h4F;
            #1 check("bp in_ready low", ir0, 0);
            @(posedge clk); #1;
            check("bp hold out_valid", ov0, 1);
            check("bp hold digit", dg0, 2);
            check("bp hold word_valid", wv0, 0);
        end
        @(negedge clk); or0 = 1'b1;
        #1 check("bp release in_ready", ir0, 1);
        @(posedge clk); #1;
        model_accept0(4'h3, 1'b0, wv);
        check("bp release digit", dg0, 3);
        check("bp release word_valid", wv0, wv);
        check("bp release word", wd0, m_word);

        // frame_start after one of two digits drops the partial word
        xfer0(8'h6D, 4'h5, 1'b0, 1'b0, "fs pre");
        @(negedge clk); iv0 = 1'b1; seg0 = 8'h7D; fs0 = 1'b1;
        #1 check("fs wins in_ready", ir0, 0);
        @(posedge clk); #1;
        m_digits.delete();
        check("fs no accept out_valid", ov0, 0);
        check("fs word_valid", wv0, 0);
        @(negedge clk); fs0 = 1'b0;
        #1 check("flush in_ready", ir0, 0);
        @(posedge clk); #1 check("flush out_valid", ov0, 0);
        xfer0(8'h4F, 4'h3, 1'b0, 1'b0, "fs d0");
        xfer0(8'h66, 4'h4, 1'b0, 1'b0, "fs d1");
        check("fs word 0x43", wd0, 8'h43);

        // randomized bytes with occasional idle cycles
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(1, 0) == 1) s = {1'($urandom_range(1, 0)), glyph[$urandom_range(15, 0)]};
            else s = 8'($urandom);
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk); iv0 = 1'b0; or0 = 1'b1;
                @(posedge clk); #1 check("rnd idle out_valid", ov0, 0);
            end
            ref_decode(s, d, e);
            xfer0(s, d, s[7], e, "rnd");
        end
        @(negedge clk); iv0 = 1'b0;

        // active-low instance, alternate glyph and 2-bit counter saturation
        xfer1(8'hC0, 4'h0, 1'b0, 1'b0, 0, "al 0xC0");
        n1 = LOOSE ? 0 : 1;
        xfer1(8'hD8, LOOSE ? 4'h7 : 4'h0, 1'b0, !LOOSE, n1, "al 0x27");
        for (int k = 0; k < 5; k++) begin
            n1 = (n1 < 3) ? n1 + 1 : 3;
            xfer1(8'hFF, 4'h0, 1'b0, 1'b1, n1, "al sat");
        end
        check("al sat final", ec1, 3);

        // async reset mid-transfer clears everything at once
        @(negedge clk); iv1 = 1'b1; seg1 = 8'hF9; iv0 = 1'b1; seg0 = 8'h06;
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("arst out_valid0", ov0, 0);
        check("arst digit0", dg0, 0);
        check("arst word0", wd0, 0);
        check("arst err_count0", ec0, 0);
        check("arst out_valid1", ov1, 0);
        check("arst digit1", dg1, 0);
        check("arst err1", er1, 0);
        check("arst word1", wd1, 0);
        check("arst word_valid1", wv1, 0);
        check("arst err_count1", ec1, 0);
        @(negedge clk); iv0 = 1'b0; iv1 = 1'b0; reset = 1'b0;
        m_digits.delete();
        m_errs = 0;
        m_word = '0;
        xfer0(8'h7F, 4'h8, 1'b0, 1'b0, "post-arst d0");
        xfer0(8'h07, 4'h7, 1'b0, 1'b0, "post-arst d1");
        check("post-arst word 0x78", wd0, 8'h78);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
